// File: rtl/discrete_range_sample_sequencer_pkg.sv
// Shared types and constants for the discrete range samplers: FSM states, LFSR taps and the
// default widths the randomizer and the sequencer must agree on.
package discrete_range_sample_sequencer_pkg;

    localparam int unsigned DefaultValueWidth        = 8;
    localparam int unsigned DefaultIndexWidth        = 2;
    localparam int unsigned DefaultNumVariables      = 4;
    localparam int unsigned DefaultRandomizerLatency = 1;
    localparam int unsigned DefaultMaxRetries        = 8;

    localparam logic [31:0] LfsrTaps       = 32'h80200003;
    localparam logic [31:0] LfsrResetValue = 32'h1;

    typedef enum logic [2:0] {
        StIdle,
        StRequest,
        StWait,
        StDraw,
        StWrite,
        StDone
    } sampler_state_e;

    // Right-shifting Galois step: the bit shifted out folds the tap mask back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state);
        return (state >> 1) ^ (state[0] ? LfsrTaps : 32'h0);
    endfunction

endpackage

// File: rtl/galois_lfsr32.sv
// 32-bit Galois LFSR with seed load; advances only when asked, so callers own the draw cadence.
module galois_lfsr32
    import discrete_range_sample_sequencer_pkg::*;
(
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic        in_advance,
    input  logic        in_load,
    input  logic [31:0] in_seed,
    output logic [31:0] out_state
);

    logic [31:0] r_state;

    // An all-zero state would lock up the register, so a zero seed falls back to the reset value.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_state <= LfsrResetValue;
        end else if (in_load) begin
            r_state <= (in_seed == 32'h0) ? LfsrResetValue : in_seed;
        end else if (in_advance) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign out_state = r_state;

endmodule

// File: rtl/discrete_range_sample_sequencer.sv
// Walks every integer variable of one MCMC sweep: asks the randomizer for a range, draws a
// uniform value in it by masked rejection sampling, and writes the value to the store.
module discrete_range_sample_sequencer
    import discrete_range_sample_sequencer_pkg::*;
#(
    parameter int unsigned MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = DefaultValueWidth,
    parameter int unsigned MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = DefaultIndexWidth,
    parameter int unsigned NUMBER_OF_VARIABLES               = DefaultNumVariables,
    parameter int unsigned RANDOMIZER_LATENCY                = DefaultRandomizerLatency,
    parameter int unsigned MAX_RETRIES                       = DefaultMaxRetries
) (
    input  logic                                         in_clock,
    input  logic                                         in_reset,
    input  logic                                         in_start,
    input  logic                                         in_seed_load,
    input  logic [31:0]                                  in_seed,
    output logic                                         out_randomizer_enable,
    output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  out_variable_index,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_range_start,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_range_end,
    input  logic                                         in_range_equal,
    output logic                                         out_write_enable,
    output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  out_write_index,
    output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_write_value,
    output logic                                         out_busy,
    output logic                                         out_done,
    output logic                                         out_error
);

    localparam int unsigned W      = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
    localparam int unsigned IDX    = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
    localparam int unsigned LatW   = $clog2(RANDOMIZER_LATENCY + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    localparam logic [IDX-1:0]    LastIndex = IDX'(NUMBER_OF_VARIABLES - 1);
    localparam logic [RetryW-1:0] LastRetry = RetryW'(MAX_RETRIES - 1);
    localparam logic [LatW-1:0]   LatLoad   = LatW'(RANDOMIZER_LATENCY);

    // Smear the highest set bit downwards to get the smallest 2^k-1 covering the span.
    function automatic logic [W:0] smear_mask(input logic [W:0] span);
        logic [W:0] m;
        m = span;
        for (int s = 1; s <= int'(W); s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

    sampler_state_e    r_state;
    logic [IDX-1:0]    r_index;
    logic [LatW-1:0]   r_lat_cnt;
    logic [RetryW-1:0] r_retry;
    logic [W-1:0]      r_start;
    logic [W-1:0]      r_end;
    logic              r_equal;
    logic              r_rand_en;
    logic              r_write_en;
    logic [IDX-1:0]    r_write_index;
    logic [W-1:0]      r_write_value;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic [31:0]       w_lfsr;
    logic [W:0]        w_span;
    logic [W:0]        w_mask;
    logic [W:0]        w_cand;
    logic              w_trivial;
    logic              w_invalid;
    logic              w_accept;
    logic              w_advance;
    logic              w_seed_load;
    logic              w_draw_done;
    logic              w_draw_error;
    logic [W-1:0]      w_draw_value;
    logic              w_unused_lfsr;

    assign w_span      = {r_end[W-1], r_end} - {r_start[W-1], r_start};
    assign w_mask      = smear_mask(w_span);
    assign w_cand      = w_lfsr[W:0] & w_mask;
    assign w_trivial   = r_equal || (w_span == '0);
    assign w_invalid   = $signed(r_end) < $signed(r_start);
    assign w_accept    = (w_cand <= w_span);
    assign w_advance   = (r_state == StDraw) && !w_trivial && !w_invalid;
    assign w_seed_load = (r_state == StIdle) && in_seed_load;

    assign w_unused_lfsr = ^w_lfsr[31:W+1];

    // Outcome of the current DRAW attempt; only meaningful while r_state == StDraw.
    always_comb begin
        w_draw_done  = 1'b0;
        w_draw_error = 1'b0;
        w_draw_value = r_start;
        if (w_trivial) begin
            w_draw_done = 1'b1;
        end else if (w_invalid) begin
            w_draw_done  = 1'b1;
            w_draw_error = 1'b1;
        end else if (w_accept) begin
            w_draw_done  = 1'b1;
            w_draw_value = r_start + w_cand[W-1:0];
        end else if (r_retry == LastRetry) begin
            w_draw_done  = 1'b1;
            w_draw_error = 1'b1;
        end
    end

    galois_lfsr32 u_lfsr (
        .in_clock   (in_clock),
        .in_reset   (in_reset),
        .in_advance (w_advance),
        .in_load    (w_seed_load),
        .in_seed    (in_seed),
        .out_state  (w_lfsr)
    );

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_state       <= StIdle;
            r_index       <= '0;
            r_lat_cnt     <= '0;
            r_retry       <= '0;
            r_start       <= '0;
            r_end         <= '0;
            r_equal       <= 1'b0;
            r_rand_en     <= 1'b0;
            r_write_en    <= 1'b0;
            r_write_index <= '0;
            r_write_value <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_rand_en  <= 1'b0;
            r_write_en <= 1'b0;
            r_done     <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (in_start) begin
                        r_index   <= '0;
                        r_error   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_rand_en <= 1'b1;
                        r_state   <= StRequest;
                    end
                end
                StRequest: begin
                    r_lat_cnt <= LatLoad;
                    r_state   <= StWait;
                end
                StWait: begin
                    r_lat_cnt <= r_lat_cnt - LatW'(1);
                    if (r_lat_cnt == LatW'(1)) begin
                        r_start <= in_range_start;
                        r_end   <= in_range_end;
                        r_equal <= in_range_equal;
                        r_retry <= '0;
                        r_state <= StDraw;
                    end
                end
                StDraw: begin
                    if (w_draw_done) begin
                        r_write_en    <= 1'b1;
                        r_write_index <= r_index;
                        r_write_value <= w_draw_value;
                        r_error       <= r_error | w_draw_error;
                        r_state       <= StWrite;
                    end else begin
                        r_retry <= r_retry + RetryW'(1);
                    end
                end
                StWrite: begin
                    if (r_index == LastIndex) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_index   <= r_index + IDX'(1);
                        r_rand_en <= 1'b1;
                        r_state   <= StRequest;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign out_randomizer_enable = r_rand_en;
    assign out_variable_index    = r_index;
    assign out_write_enable      = r_write_en;
    assign out_write_index       = r_write_index;
    assign out_write_value       = r_write_value;
    assign out_busy              = r_busy;
    assign out_done              = r_done;
    assign out_error             = r_error;

endmodule

// File: tb/tb_discrete_range_sample_sequencer.sv
// Randomized bench for discrete_range_sample_sequencer: a behavioural model predicts values,
// draw counts, error and sweep length from the sampling rules.
module tb_discrete_range_sample_sequencer;

    localparam int W   = 8;
    localparam int IDX = 2;
    localparam int NV  = 4;
    localparam int LAT = 1;
    localparam int MR  = 8;

    logic           in_clock = 1'b0;
    logic           in_reset = 1'b0;
    logic           in_start = 1'b0;
    logic           in_seed_load = 1'b0;
    logic [31:0]    in_seed = 32'h0;
    logic [W-1:0]   in_range_start = '0;
    logic [W-1:0]   in_range_end = '0;
    logic           in_range_equal = 1'b0;
    logic           out_randomizer_enable;
    logic [IDX-1:0] out_variable_index;
    logic           out_write_enable;
    logic [IDX-1:0] out_write_index;
    logic [W-1:0]   out_write_value;
    logic           out_busy;
    logic           out_done;
    logic           out_error;

    discrete_range_sample_sequencer #(
        .MAX_BIT_WIDTH_OF_INTEGER_VARIABLE (W),
        .MAX_BIT_WIDTH_OF_VARIABLES_INDEX  (IDX),
        .NUMBER_OF_VARIABLES               (NV),
        .RANDOMIZER_LATENCY                (LAT),
        .MAX_RETRIES                       (MR)
    ) dut (
        .in_clock              (in_clock),
        .in_reset              (in_reset),
        .in_start              (in_start),
        .in_seed_load          (in_seed_load),
        .in_seed               (in_seed),
        .out_randomizer_enable (out_randomizer_enable),
        .out_variable_index    (out_variable_index),
        .in_range_start        (in_range_start),
        .in_range_end          (in_range_end),
        .in_range_equal        (in_range_equal),
        .out_write_enable      (out_write_enable),
        .out_write_index       (out_write_index),
        .out_write_value       (out_write_value),
        .out_busy              (out_busy),
        .out_done              (out_done),
        .out_error             (out_error)
    );

    always #5 in_clock = ~in_clock;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_lfsr;
    int exp_val[$];
    int exp_draws[$];
    bit exp_err;
    int exp_total;

    int cap_idx[$];
    int cap_val[$];
    int cap_gap[$];
    int cap_done;
    int cap_done_cycle;
    bit cap_err_end;
    bit cap_err_c1;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
    endfunction

    // Per variable: equal/empty span -> start; inverted -> start with error; otherwise up to MR
    // uniform draws under the covering power-of-two mask.
    task automatic model_sweep(input int s, input int e, input bit eq);
        int val;
        int draws;
        int span;
        int mask;
        int cand;
        bit got;
        exp_val.delete();
        exp_draws.delete();
        exp_err = 1'b0;
        exp_total = 1;
        for (int v = 0; v < NV; v++) begin
            val = s;
            draws = 1;
            if (!eq && s != e) begin
                if (e < s) begin
                    exp_err = 1'b1;
                end else begin
                    span = e - s;
                    mask = 0;
                    while (mask < span) mask = mask * 2 + 1;
                    got = 1'b0;
                    for (int t = 1; t <= MR; t++) begin
                        if (!got) begin
                            cand = int'(m_lfsr & 32'(mask));
                            m_lfsr = lfsr_step(m_lfsr);
                            draws = t;
                            if (cand <= span) begin
                                val = s + cand;
                                got = 1'b1;
                            end
                        end
                    end
                    if (!got) exp_err = 1'b1;
                end
            end
            exp_val.push_back(val);
            exp_draws.push_back(draws);
            exp_total += 2 + LAT + draws;
        end
    endtask

    task automatic load_seed(input logic [31:0] s);
        in_seed_load = 1'b1;
        in_seed = s;
        @(negedge in_clock);
        in_seed_load = 1'b0;
        m_lfsr = (s == 32'h0) ? 32'h1 : s;
    endtask

    task automatic set_range(input int s, input int e, input bit eq);
        in_range_start = W'(s);
        in_range_end = W'(e);
        in_range_equal = eq;
    endtask

    // Starts one sweep and records writes (index, signed value, enable-to-write gap) and done.
    task automatic run_sweep(input int disturb_cycle, input logic [31:0] disturb_seed);
        int cyc;
        int en_cycle;
        cap_idx.delete();
        cap_val.delete();
        cap_gap.delete();
        cap_done = 0;
        cap_done_cycle = -1;
        cap_err_end = 1'b0;
        en_cycle = 0;
        in_start = 1'b1;
        @(negedge in_clock);
        in_start = 1'b0;
        cyc = 1;
        while (cap_done_cycle < 0 || cyc < cap_done_cycle + 4) begin
            if (cyc > 400) break;
            if (cyc == 1) cap_err_c1 = out_error;
            if (out_randomizer_enable) en_cycle = cyc;
            if (out_write_enable) begin
                cap_idx.push_back(int'(out_write_index));
                cap_val.push_back(int'($signed(out_write_value)));
                cap_gap.push_back(cyc - en_cycle);
            end
            if (out_done) begin
                cap_done++;
                if (cap_done_cycle < 0) begin
                    cap_done_cycle = cyc;
                    cap_err_end = out_error;
                end
            end
            in_start = (cyc == disturb_cycle);
            in_seed_load = (cyc == disturb_cycle);
            in_seed = disturb_seed;
            @(negedge in_clock);
            cyc++;
        end
        in_start = 1'b0;
        in_seed_load = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({out_randomizer_enable, out_variable_index, out_write_enable, out_write_index,
             out_write_value, out_busy, out_done, out_error} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {out_randomizer_enable,
                     out_variable_index, out_write_enable, out_write_index, out_write_value,
                     out_busy, out_done, out_error});
        end
        @(negedge in_clock);
        in_reset = 1'b1;
        @(negedge in_clock);
        // No seed load: sampling must start from the reset LFSR state of 1.
        m_lfsr = 32'h1;
        set_range(-128, 127, 1'b0);
        model_sweep(-128, 127, 1'b0);
        run_sweep(-1, 32'h0);
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (i >= cap_val.size() || cap_val[i] !== exp_val[i]) begin
                failures++;
                $display("FAIL reset_lfsr_value[%0d]: got %0d required %0d", i,
                         (i < cap_val.size()) ? cap_val[i] : -999, exp_val[i]);
            end
        end
    endtask

    task automatic test_basic;
        load_seed(32'hACE1);
        set_range(-3, 4, 1'b0);
        model_sweep(-3, 4, 1'b0);
        run_sweep(-1, 32'h0);
        checks++;
        if (cap_val.size() != NV) begin
            failures++;
            $display("FAIL basic_write_count: got %0d required %0d", cap_val.size(), NV);
        end
        for (int i = 0; i < NV && i < cap_val.size(); i++) begin
            checks++;
            if (cap_idx[i] !== i || cap_val[i] < -3 || cap_val[i] > 4 ||
                cap_val[i] !== exp_val[i] || cap_gap[i] !== LAT + 1 + exp_draws[i]) begin
                failures++;
                $display("FAIL basic_write[%0d]: got idx=%0d val=%0d gap=%0d required idx=%0d val=%0d gap=%0d",
                         i, cap_idx[i], cap_val[i], cap_gap[i], i, exp_val[i],
                         LAT + 1 + exp_draws[i]);
            end
        end
        checks++;
        if (cap_done !== 1 || cap_done_cycle !== exp_total || cap_err_end !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: got pulses=%0d cycle=%0d err=%0d required 1 %0d 0",
                     cap_done, cap_done_cycle, cap_err_end, exp_total);
        end
    endtask

    task automatic test_random;
        int s;
        int e;
        bit eq;
        for (int it = 0; it < 8; it++) begin
            load_seed($urandom);
            s = int'($urandom_range(0, 255)) - 128;
            e = int'($urandom_range(0, 255)) - 128;
            if (it == 2) e = s;
            if (it == 5) e = s + 1 > 127 ? s : s + 1;
            eq = ($urandom_range(0, 4) == 0);
            set_range(s, e, eq);
            model_sweep(s, e, eq);
            run_sweep(-1, 32'h0);
            for (int i = 0; i < NV; i++) begin
                checks++;
                if (i >= cap_val.size() || cap_idx[i] !== i || cap_val[i] !== exp_val[i] ||
                    cap_gap[i] !== LAT + 1 + exp_draws[i]) begin
                    failures++;
                    $display("FAIL random%0d_write[%0d]: got val=%0d gap=%0d required val=%0d gap=%0d (range %0d..%0d eq=%0d)",
                             it, i, (i < cap_val.size()) ? cap_val[i] : -999,
                             (i < cap_gap.size()) ? cap_gap[i] : -1, exp_val[i],
                             LAT + 1 + exp_draws[i], s, e, eq);
                end
            end
            checks++;
            if (cap_done !== 1 || cap_done_cycle !== exp_total || cap_err_end !== exp_err) begin
                failures++;
                $display("FAIL random%0d_done: got pulses=%0d cycle=%0d err=%0d required 1 %0d %0d",
                         it, cap_done, cap_done_cycle, cap_err_end, exp_total, exp_err);
            end
        end
    endtask

    task automatic test_equal;
        int first_vals[$];
        logic [31:0] seed;
        seed = $urandom | 32'h100;
        load_seed(seed);
        set_range(-3, 4, 1'b0);
        run_sweep(-1, 32'h0);
        first_vals = cap_val;
        load_seed(seed);
        set_range(7, 7, 1'b1);
        run_sweep(-1, 32'h0);
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (i >= cap_val.size() || cap_val[i] !== 7 || cap_gap[i] !== LAT + 2) begin
                failures++;
                $display("FAIL equal_write[%0d]: got val=%0d gap=%0d required val=7 gap=%0d", i,
                         (i < cap_val.size()) ? cap_val[i] : -999,
                         (i < cap_gap.size()) ? cap_gap[i] : -1, LAT + 2);
            end
        end
        set_range(-3, 4, 1'b0);
        run_sweep(-1, 32'h0);
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (i >= cap_val.size() || i >= first_vals.size() || cap_val[i] !== first_vals[i]) begin
                failures++;
                $display("FAIL equal_lfsr_hold[%0d]: got %0d required %0d", i,
                         (i < cap_val.size()) ? cap_val[i] : -999,
                         (i < first_vals.size()) ? first_vals[i] : -999);
            end
        end
    endtask

    task automatic test_invalid;
        load_seed(32'h1234_5678);
        set_range(5, 2, 1'b0);
        run_sweep(-1, 32'h0);
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (i >= cap_val.size() || cap_val[i] !== 5 || cap_gap[i] !== LAT + 2) begin
                failures++;
                $display("FAIL invalid_write[%0d]: got val=%0d required val=5", i,
                         (i < cap_val.size()) ? cap_val[i] : -999);
            end
        end
        checks++;
        if (cap_err_end !== 1'b1) begin
            failures++;
            $display("FAIL invalid_error: got %0d required 1", cap_err_end);
        end
        // LFSR must still hold the loaded seed, and the next start clears the error.
        set_range(-20, 30, 1'b0);
        model_sweep(-20, 30, 1'b0);
        run_sweep(-1, 32'h0);
        checks++;
        if (cap_err_c1 !== 1'b0 || cap_err_end !== exp_err) begin
            failures++;
            $display("FAIL invalid_error_clear: got c1=%0d end=%0d required 0 %0d", cap_err_c1,
                     cap_err_end, exp_err);
        end
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (i >= cap_val.size() || cap_val[i] !== exp_val[i]) begin
                failures++;
                $display("FAIL invalid_next_value[%0d]: got %0d required %0d", i,
                         (i < cap_val.size()) ? cap_val[i] : -999, exp_val[i]);
            end
        end
    endtask

    task automatic test_exhaust;
        logic [31:0] seed;
        logic [31:0] x;
        bit ok;
        bit found;
        found = 1'b0;
        seed = 32'h1;
        for (int k = 0; k < 400000 && !found; k++) begin
            seed = $urandom;
            x = seed;
            ok = (seed != 32'h0);
            for (int t = 0; t < MR; t++) begin
                if ((x & 32'h7) < 32'h5) ok = 1'b0;
                x = lfsr_step(x);
            end
            found = ok;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL exhaust_seed_search: got none required a seed");
        end else begin
            load_seed(seed);
            set_range(10, 14, 1'b0);
            model_sweep(10, 14, 1'b0);
            run_sweep(-1, 32'h0);
            checks++;
            if (cap_val.size() < 1 || cap_val[0] !== 10 || cap_gap[0] !== LAT + 1 + MR) begin
                failures++;
                $display("FAIL exhaust_fallback: got val=%0d gap=%0d required val=10 gap=%0d",
                         (cap_val.size() > 0) ? cap_val[0] : -999,
                         (cap_gap.size() > 0) ? cap_gap[0] : -1, LAT + 1 + MR);
            end
            checks++;
            if (cap_err_end !== 1'b1) begin
                failures++;
                $display("FAIL exhaust_error: got %0d required 1", cap_err_end);
            end
            for (int i = 1; i < NV; i++) begin
                checks++;
                if (i >= cap_val.size() || cap_val[i] !== exp_val[i]) begin
                    failures++;
                    $display("FAIL exhaust_value[%0d]: got %0d required %0d", i,
                             (i < cap_val.size()) ? cap_val[i] : -999, exp_val[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int enables;
        int cyc;
        int bad;
        load_seed(32'h0BAD_F00D);
        set_range(-3, 4, 1'b0);
        in_start = 1'b1;
        @(negedge in_clock);
        in_start = 1'b0;
        enables = 0;
        cyc = 0;
        while (enables < 3 && cyc < 200) begin
            if (out_randomizer_enable) enables++;
            if (enables < 3) begin
                @(negedge in_clock);
                cyc++;
            end
        end
        @(negedge in_clock);
        checks++;
        if (out_busy !== 1'b1 || out_variable_index !== 2'd2 || enables !== 3) begin
            failures++;
            $display("FAIL reset_mid_pre: got busy=%0d idx=%0d enables=%0d required 1 2 3",
                     out_busy, out_variable_index, enables);
        end
        in_reset = 1'b0;
        #1;
        checks++;
        if ({out_randomizer_enable, out_variable_index, out_write_enable, out_write_index,
             out_write_value, out_busy, out_done, out_error} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h required 0", {out_randomizer_enable,
                     out_variable_index, out_write_enable, out_write_index, out_write_value,
                     out_busy, out_done, out_error});
        end
        @(negedge in_clock);
        in_reset = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge in_clock);
            if (out_write_enable || out_done || out_busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_mid_quiet: got %0d active cycles required 0", bad);
        end
        m_lfsr = 32'h1;
        model_sweep(-3, 4, 1'b0);
        run_sweep(-1, 32'h0);
        checks++;
        if (cap_idx.size() != NV || cap_idx[0] !== 0 || cap_val[0] !== exp_val[0] ||
            cap_done !== 1) begin
            failures++;
            $display("FAIL reset_mid_restart: got writes=%0d first_idx=%0d first_val=%0d done=%0d required %0d 0 %0d 1",
                     cap_idx.size(), (cap_idx.size() > 0) ? cap_idx[0] : -1,
                     (cap_val.size() > 0) ? cap_val[0] : -999, cap_done, NV, exp_val[0]);
        end
    endtask

    task automatic test_back_to_back_busy;
        load_seed(32'h5EED_0001);
        set_range(-128, 127, 1'b0);
        model_sweep(-128, 127, 1'b0);
        run_sweep(5, 32'hDEAD_BEEF);
        checks++;
        if (cap_done !== 1 || cap_done_cycle !== 4 * (3 + LAT) + 1) begin
            failures++;
            $display("FAIL busy_timing: got pulses=%0d cycle=%0d required 1 %0d", cap_done,
                     cap_done_cycle, 4 * (3 + LAT) + 1);
        end
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (i >= cap_val.size() || cap_idx[i] !== i || cap_val[i] !== exp_val[i]) begin
                failures++;
                $display("FAIL busy_value[%0d]: got %0d required %0d", i,
                         (i < cap_val.size()) ? cap_val[i] : -999, exp_val[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_equal();
        test_invalid();
        test_exhaust();
        test_reset_mid();
        test_back_to_back_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
